pattern_detector_apb: RTL and testbench

Parametrised serial bit-pattern detector, the successor to the fixed 5-bit detector. Pattern, compare mask, active length and overlap mode are programmed over an APB3 slave. The block counts hits and raises a maskable sticky interrupt. It sits on the peripheral APB bus and watches a 1-bit serial stream qualified by data_valid.

---
 rtl/pattern_detector_apb.sv | 172 +++++++++++++++++
 tb/tb_pattern_detector_apb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_detector_apb.sv
// pattern_detector_apb: programmable serial bit-pattern detector with an APB3 slave.
// Watches a 1-bit stream qualified by data_valid, compares the newest bits against
// PATTERN under MASK and an active length, counts hits and raises a sticky,
// maskable interrupt.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   data_in, data_valid   serial bit and its qualifier
//   psel, penable, pwrite, paddr, pwdata   APB3 request
//   prdata, pready, pslverr                APB3 response (combinational, zero wait)
//   pattern_det           one-cycle pulse per detected pattern
//   irq                   STATUS.HIT & CTRL.IE
module pattern_detector_apb #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_in,
  input  logic        data_valid,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [4:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        pattern_det,
  output logic        irq
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  localparam logic [2:0] A_PATTERN = 3'd0;
  localparam logic [2:0] A_MASK    = 3'd1;
  localparam logic [2:0] A_CTRL    = 3'd2;
  localparam logic [2:0] A_STATUS  = 3'd3;
  localparam logic [2:0] A_COUNT   = 3'd4;

  logic [PAT_W-1:0]  pattern_q;
  logic [PAT_W-1:0]  mask_q;
  logic              en_q;
  logic              overlap_q;
  logic              ie_q;
  logic [4:0]        len_q;
  logic              hit_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PAT_W-1:0]  sr_q;
  logic [FILL_W-1:0] fill_q;

  logic [2:0]        widx;
  logic              mapped;
  logic              wr;
  logic              wr_pat, wr_mask, wr_ctrl, wr_sts, wr_cnt, cfg_wr;
  logic              shift;
  logic [PAT_W-1:0]  sr_n;
  logic [FILL_W-1:0] fill_n;
  logic [FILL_W-1:0] eff_len;
  logic [PAT_W-1:0]  lenmask;
  logic              hit;
  logic              unused_bits;

  // APB decode; word index only, byte offset bits are ignored
  assign widx    = paddr[4:2];
  assign mapped  = (widx <= A_COUNT);
  assign wr      = psel & penable & pwrite;
  assign wr_pat  = wr & (widx == A_PATTERN);
  assign wr_mask = wr & (widx == A_MASK);
  assign wr_ctrl = wr & (widx == A_CTRL);
  assign wr_sts  = wr & (widx == A_STATUS);
  assign wr_cnt  = wr & (widx == A_COUNT);
  assign cfg_wr  = wr_pat | wr_mask | wr_ctrl;

  assign pready  = 1'b1;
  assign pslverr = psel & penable & ~mapped;
  assign irq     = hit_q & ie_q;

  assign unused_bits = ^{paddr[1:0], pwdata};

  // Effective length and the mask selecting the low eff_len bits
  always_comb begin
    eff_len = FILL_W'(PAT_W);
    if ((len_q != 5'd0) && (32'(len_q) <= PAT_W)) begin
      eff_len = FILL_W'(len_q);
    end
    lenmask = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      lenmask[i] = (i < 32'(eff_len));
    end
  end

  // Match is evaluated on the post-shift value; a config write suppresses it
  always_comb begin
    shift  = en_q & data_valid;
    sr_n   = {sr_q[PAT_W-2:0], data_in};
    fill_n = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
    hit    = shift & ~cfg_wr & (fill_n >= eff_len) &
             (((sr_n ^ pattern_q) & mask_q & lenmask) == '0);
  end

  // Register read mux
  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      case (widx)
        A_PATTERN: prdata = 32'(pattern_q);
        A_MASK:    prdata = 32'(mask_q);
        A_CTRL:    prdata = {19'd0, len_q, 5'd0, ie_q, overlap_q, en_q};
        A_STATUS:  prdata = {31'd0, hit_q};
        A_COUNT:   prdata = 32'(cnt_q);
        default:   prdata = '0;
      endcase
    end
  end

  // Configuration, status, counter and shift state
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q   <= '0;
      mask_q      <= '1;
      en_q        <= 1'b0;
      overlap_q   <= 1'b0;
      ie_q        <= 1'b0;
      len_q       <= '0;
      hit_q       <= 1'b0;
      cnt_q       <= '0;
      sr_q        <= '0;
      fill_q      <= '0;
      pattern_det <= 1'b0;
    end else begin
      pattern_det <= hit;

      if (wr_pat)  pattern_q <= pwdata[PAT_W-1:0];
      if (wr_mask) mask_q    <= pwdata[PAT_W-1:0];
      if (wr_ctrl) begin
        en_q      <= pwdata[0];
        overlap_q <= pwdata[1];
        ie_q      <= pwdata[2];
        len_q     <= pwdata[12:8];
      end

      // A hit wins over a same-edge W1C
      if (hit) begin
        hit_q <= 1'b1;
      end else if (wr_sts && pwdata[0]) begin
        hit_q <= 1'b0;
      end

      // A hit on the clearing edge leaves the count at 1
      if (hit) begin
        if (wr_cnt) begin
          cnt_q <= CNT_W'(1);
        end else if (cnt_q != '1) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else if (wr_cnt) begin
        cnt_q <= '0;
      end

      if (shift) begin
        sr_q <= sr_n;
      end

      if (cfg_wr) begin
        fill_q <= '0;
      end else if (shift) begin
        fill_q <= (hit && !overlap_q) ? '0 : fill_n;
      end
    end
  end

endmodule

// File: tb/tb_pattern_detector_apb.sv
// Testbench for pattern_detector_apb: table of APB/bit operations with
// hand-computed expected values, plus hand-written reset sequences.
module tb_pattern_detector_apb;

  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_in;
  logic        data_valid;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        pattern_det;
  logic        irq;

  int checks = 0;
  int errors = 0;

  pattern_detector_apb #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .pattern_det (pattern_det),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {OP_BIT, OP_WR, OP_RD, OP_IRQ} op_e;

  typedef struct {
    op_e         op;
    logic [4:0]  a;
    logic [31:0] x;
    logic        v;
    logic        d;
    logic        det;
  } vec_t;

  vec_t vq[$];

  function automatic void vb(input logic d, input logic det);
    vq.push_back('{OP_BIT, 5'd0, 32'd0, 1'b1, d, det});
  endfunction
  function automatic void vgap(input logic d);
    vq.push_back('{OP_BIT, 5'd0, 32'd0, 1'b0, d, 1'b0});
  endfunction
  function automatic void vw(input logic [4:0] a, input logic [31:0] x);
    vq.push_back('{OP_WR, a, x, 1'b0, 1'b0, 1'b0});
  endfunction
  function automatic void vwb(input logic [4:0] a, input logic [31:0] x,
                              input logic d, input logic det);
    vq.push_back('{OP_WR, a, x, 1'b1, d, det});
  endfunction
  function automatic void vr(input logic [4:0] a, input logic [31:0] x);
    vq.push_back('{OP_RD, a, x, 1'b0, 1'b0, 1'b0});
  endfunction
  function automatic void virq(input logic x);
    vq.push_back('{OP_IRQ, 5'd0, {31'd0, x}, 1'b0, 1'b0, 1'b0});
  endfunction
  function automatic void vstream(input logic [7:0] bits, input int n, input logic [7:0] dets);
    for (int k = n - 1; k >= 0; k--) vb(bits[k], dets[k]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; data_valid = 1'b0;
  endtask

  task automatic do_bit(input logic v, input logic d);
    data_valid = v; data_in = d;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic do_wr(input logic [4:0] a, input logic [31:0] x, input logic v, input logic d);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = x; data_valid = 1'b0;
    tick();
    penable = 1'b1; data_valid = v; data_in = d;
    tick();
    idle();
  endtask

  task automatic do_rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
    logic [4:0] aa;
    aa = a;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = a;
    #1;
    chk({nm, "_prdata"}, prdata, exp);
    chk({nm, "_pslverr"}, {31'd0, pslverr}, {31'd0, (aa[4:2] > 3'd4)});
    idle();
  endtask

  initial begin
    rst = 1'b1; data_in = 1'b0; paddr = '0; pwdata = '0;
    idle();
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_det", {31'd0, pattern_det}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_pready", {31'd0, pready}, 32'd1);
    chk("rst_pslverr_idle", {31'd0, pslverr}, 32'd0);
    do_rd(5'h00, 32'h0,  "rst_pattern");
    do_rd(5'h04, 32'hFF, "rst_mask");
    do_rd(5'h08, 32'h0,  "rst_ctrl");
    do_rd(5'h0C, 32'h0,  "rst_status");
    do_rd(5'h10, 32'h0,  "rst_count");

    // Full-length pattern, LEN=0
    vw(5'h00, 32'hB5); vw(5'h08, 32'h1);
    vstream(8'hB5, 8, 8'h01);
    vr(5'h10, 1); vr(5'h0C, 1);
    vw(5'h0C, 1); vw(5'h10, 0); vr(5'h10, 0); vr(5'h0C, 0);
    // LEN beyond PAT_W falls back to PAT_W
    vw(5'h08, 32'h1F01); vr(5'h08, 32'h1F01);
    vstream(8'hB5, 8, 8'h01);
    vr(5'h10, 1);
    // Length 3 with don't-care middle bit, overlap
    vw(5'h00, 32'h05); vw(5'h04, 32'h05); vw(5'h08, 32'h303); vw(5'h10, 0);
    vstream(8'b0010_1111, 6, 8'b0000_1011);
    vr(5'h10, 3);
    // Overlap on / off, full mask
    vw(5'h04, 32'hFF); vw(5'h10, 0);
    vstream(8'b0001_0101, 5, 8'b0000_0101);
    vr(5'h10, 2);
    vw(5'h08, 32'h301);
    vstream(8'b0001_0101, 5, 8'b0000_0100);
    vr(5'h10, 3);
    // Config write coinciding with a valid bit: shifted but fill cleared
    vw(5'h08, 32'h303);
    vb(1, 0); vb(0, 0);
    vwb(5'h00, 32'h05, 1, 0);
    vstream(8'b0000_0101, 4, 8'b0000_0001);
    // data_valid gating and interrupt with same-edge W1C
    vw(5'h0C, 1); vw(5'h10, 0); vw(5'h08, 32'h305); virq(0);
    vb(1, 0); vb(0, 0);
    vgap(1); vgap(0); vgap(1); vgap(1);
    vb(1, 1); virq(1); vr(5'h0C, 1);
    vb(1, 0); vb(0, 0);
    vwb(5'h0C, 1, 1, 1); virq(1); vr(5'h0C, 1);
    vw(5'h0C, 1); virq(0); vr(5'h0C, 0);
    // Counter saturation and same-edge clear
    vw(5'h08, 32'h203); vw(5'h00, 1); vw(5'h04, 1); vw(5'h10, 0); vw(5'h0C, 1);
    vstream(8'b0011_1111, 6, 8'b0001_1111);
    vr(5'h10, 3);
    vwb(5'h10, 0, 1, 1);
    vr(5'h10, 1);
    // Unmapped accesses
    vr(5'h14, 0); vr(5'h1C, 0);
    vw(5'h18, 32'hFFFF_FFFF);
    vr(5'h00, 1); vr(5'h04, 1); vr(5'h08, 32'h203);

    foreach (vq[i]) begin
      case (vq[i].op)
        OP_BIT: begin
          do_bit(vq[i].v, vq[i].d);
          chk($sformatf("det_bit[%0d]", i), {31'd0, pattern_det}, {31'd0, vq[i].det});
        end
        OP_WR: begin
          do_wr(vq[i].a, vq[i].x, vq[i].v, vq[i].d);
          chk($sformatf("det_wr[%0d]", i), {31'd0, pattern_det}, {31'd0, vq[i].det});
        end
        OP_RD:  do_rd(vq[i].a, vq[i].x, $sformatf("rd[%0d]", i));
        default: chk($sformatf("irq[%0d]", i), {31'd0, irq}, vq[i].x);
      endcase
    end

    // Reset mid-stream: 7 of 8 bits in, 8th bit on the reset edge
    do_wr(5'h00, 32'hB5, 1'b0, 1'b0);
    do_wr(5'h04, 32'hFF, 1'b0, 1'b0);
    do_wr(5'h08, 32'h5, 1'b0, 1'b0);
    do_wr(5'h10, 32'h0, 1'b0, 1'b0);
    for (int k = 7; k >= 1; k--) begin
      logic [7:0] p;
      p = 8'hB5;
      do_bit(1'b1, p[k]);
      chk($sformatf("mid_det[%0d]", k), {31'd0, pattern_det}, 32'd0);
    end
    rst = 1'b1; data_valid = 1'b1; data_in = 1'b1;
    tick();
    rst = 1'b0; data_valid = 1'b0;
    chk("mid_rst_det", {31'd0, pattern_det}, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    do_bit(1'b1, 1'b1);
    chk("post_rst_det", {31'd0, pattern_det}, 32'd0);
    do_rd(5'h04, 32'hFF, "post_rst_mask");
    do_rd(5'h08, 32'h0,  "post_rst_ctrl");
    do_rd(5'h0C, 32'h0,  "post_rst_status");
    do_rd(5'h10, 32'h0,  "post_rst_count");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
